// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared defaults and loader state type for the instruction-memory loader
//
// Purpose: default instruction width / address width and the loader FSM state
//          encoding, imported by imem_loader and word_packer.
// Ports:   none (package).

package imem_pkg;

    localparam int IMEM_N = 32;   // instruction word width in bits
    localparam int IMEM_R = 6;    // word-address width, depth = 2**IMEM_R

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - big-endian byte-to-word shift register
//
// Purpose: collects bytes into an n-bit word, first byte ending up in the
//          most significant byte lane (hex-file word order).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   shift_en     shift byte_in into the word this cycle
//   byte_in[7:0] byte to shift in
//   clear        restart the byte count and zero the word (wins over shift_en)
//   word[n-1:0]  assembled word (stable while shift_en is low)
//   full         high in the cycle whose shift completes the word

module word_packer
    import imem_pkg::*;
#(
    parameter int n = IMEM_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic [7:0]   byte_in,
    input  logic         clear,
    output logic [n-1:0] word,
    output logic         full
);

    localparam int         bpw      = n / 8;
    localparam logic [1:0] last_idx = 2'(bpw - 1);

    logic [1:0] cnt;

    // Combinational so the loader can leave RECV on the very edge that
    // accepts the final byte, rather than one cycle later.
    assign full = shift_en && (cnt == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (clear) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (shift_en) begin
            cnt  <= (cnt == last_idx) ? 2'd0 : cnt + 2'd1;
            word <= {word[n-9:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction memory from a byte stream while holding the CPU in reset
//
// Purpose: on start, receives len_words big-endian words from a byte stream
//          and writes each one to an external instruction memory.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a load (honoured in IDLE or DONE only)
//   len_words[r:0]       words to load, latched on an accepted start
//   rx_valid, rx_data    byte stream in
//   rx_ready             byte accepted when rx_valid && rx_ready
//   we, waddr, wdata     one-cycle memory write per word
//   busy                 load in progress (CPU held in reset)
//   done                 last load finished, held until the next start
//   len_err              last accepted len_words exceeded memory depth

module imem_loader
    import imem_pkg::*;
#(
    parameter int n = IMEM_N,
    parameter int r = IMEM_R
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [r:0]   len_words,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         we,
    output logic [r-1:0] waddr,
    output logic [n-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         len_err
);

    localparam logic [r:0] depth = {1'b1, {r{1'b0}}};
    localparam logic [r:0] one   = {{r{1'b0}}, 1'b1};

    loader_state_t state;
    logic [r:0]    len;
    // One bit wider than waddr so a full-depth load ends at 2**r without
    // wrapping back to 0 before the completion compare.
    logic [r:0]    wcnt;
    logic [r:0]    wnext;
    logic          start_ok;
    logic          accept;
    logic          pk_full;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign accept   = rx_valid && rx_ready;
    assign wnext    = wcnt + one;

    // All status outputs are pure decodes of the state register, so an
    // asynchronous reset drops them immediately.
    assign rx_ready = (state == RECV);
    assign we       = (state == WRITE);
    assign busy     = (state == RECV) || (state == WRITE);
    assign done     = (state == DONE);
    assign waddr    = wcnt[r-1:0];

    word_packer #(.n(n)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .byte_in  (rx_data),
        .clear    (start_ok),
        .word     (wdata),
        .full     (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len     <= '0;
            wcnt    <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        len     <= len_words;
                        wcnt    <= '0;
                        len_err <= (len_words > depth);
                        state   <= ((len_words != '0) && (len_words <= depth)) ? RECV : DONE;
                    end
                end
                RECV: begin
                    if (pk_full) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    wcnt  <= wnext;
                    state <= (wnext < len) ? RECV : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized scoreboard bench for imem_loader

module tb_imem_loader;

    localparam int N     = 32;
    localparam int R     = 6;
    localparam int DEPTH = 1 << R;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [R:0]   len_words = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_ready;
    logic         we;
    logic [R-1:0] waddr;
    logic [N-1:0] wdata;
    logic         busy;
    logic         done;
    logic         len_err;

    imem_loader #(.n(N), .r(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_words (len_words),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int         compared   = 0;
    int         mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every write the DUT presents is popped against the model.
    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'd0, wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {58'd0, waddr}, 64'(e.addr));
                check("wr_data", {32'd0, wdata}, {32'd0, e.data});
            end
        end
    end

    // Reference model: a valid load writes word i (bytes 4i..4i+3, first byte
    // most significant) at address i; an empty or oversized load writes nothing.
    task automatic plan_load(input int len);
        if (len >= 1 && len <= DEPTH) begin
            for (int i = 0; i < len; i++) begin
                wr_t e;
                e.addr = i;
                e.data = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
                exp_q.push_back(e);
            end
        end
    endtask

    // mode 0: random bytes, 1: word i holds value i, 2: bq already filled
    task automatic make_bytes(input int len, input int mode);
        if (mode == 2) return;
        bq.delete();
        if (len < 1 || len > DEPTH) return;
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = (mode == 1) ? 32'(i) : $urandom;
            bq.push_back(w[31:24]);
            bq.push_back(w[23:16]);
            bq.push_back(w[15:8]);
            bq.push_back(w[7:0]);
        end
    endtask

    task automatic do_start(input int len);
        @(posedge clk); #1;
        start     = 1'b1;
        len_words = (R+1)'(len);
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // stall: percent of cycles with rx_valid low, or -1 to toggle 1/0.
    // Called and returns at posedge+1.
    task automatic feed(input int stall, input int pulse_at, input int max_bytes, output int first_acc);
        int  idx = 0;
        int  guard = 0;
        bit  pulsed = 0;
        bit  acc;
        first_acc = -1;
        while (idx < max_bytes && guard < 5000) begin
            if (stall < 0) rx_valid = (guard % 2 == 0);
            else           rx_valid = ($urandom_range(99) >= stall);
            rx_data = bq[idx];
            if (pulse_at >= 0 && idx == pulse_at && !pulsed) begin
                start     = 1'b1;
                len_words = 7'd5;
                pulsed    = 1;
            end
            @(negedge clk);
            acc = rx_valid && rx_ready;
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) idx++;
            guard++;
        end
        rx_valid = 1'b0;
        if (guard >= 5000) check("feed_timeout", 64'(idx), 64'(max_bytes));
    endtask

    task automatic wait_done(input logic exp_err, output int dcyc);
        int k = 0;
        dcyc = -1;
        while (k < 400) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        dcyc = cyc;
        check("done_reached", {63'd0, done}, 64'd1);
        check("len_err", {63'd0, len_err}, {63'd0, exp_err});
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_load(input int len, input int mode, input int stall, input int pulse_at, output int acc_to_done);
        int first_acc;
        int dcyc;
        bit valid;
        valid = (len >= 1 && len <= DEPTH);
        make_bytes(len, mode);
        plan_load(len);
        do_start(len);
        @(negedge clk);
        acc_to_done = -1;
        if (valid) begin
            check("busy_in_load", {63'd0, busy}, 64'd1);
            check("done_in_load", {63'd0, done}, 64'd0);
            check("ready_in_recv", {63'd0, rx_ready}, 64'd1);
            @(posedge clk); #1;
            feed(stall, pulse_at, bq.size(), first_acc);
            wait_done(1'b0, dcyc);
            acc_to_done = dcyc - first_acc;
        end else begin
            check("ready_bad_len", {63'd0, rx_ready}, 64'd0);
            check("done_bad_len", {63'd0, done}, 64'd1);
            check("len_err_bad_len", {63'd0, len_err}, {63'd0, (len > DEPTH)});
            @(negedge clk);
            check("no_write_bad_len", {63'd0, we}, 64'd0);
        end
    endtask

    initial begin
        int t;
        int first_acc;

        // Reset state
        #12;
        check("rst_we", {63'd0, we}, 64'd0);
        check("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_len_err", {63'd0, len_err}, 64'd0);
        check("rst_waddr", {58'd0, waddr}, 64'd0);
        check("rst_wdata", {32'd0, wdata}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed two-word load with continuous stream and latency
        bq = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h00};
        run_load(2, 2, 0, -1, t);
        check("accept_to_done_cycles", 64'(t), 64'd10);

        // Empty load, then oversized load
        run_load(0, 0, 0, -1, t);
        run_load(65, 0, 0, -1, t);

        // Full-depth load of incrementing words (last write at 63)
        run_load(64, 1, 0, -1, t);
        check("full_depth_cycles", 64'(t), 64'(DEPTH * 5 - 5 + 1 + 4));

        // Toggling rx_valid, single word
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(1, 2, -1, -1, t);

        // Start pulsed mid-load is ignored
        run_load(2, 0, 0, 3, t);
        check("pulse_ignored_cycles", 64'(t), 64'd10);

        // Reset after two bytes of the first word
        make_bytes(2, 0);
        plan_load(2);
        do_start(2);
        feed(0, -1, 2, first_acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_rx_ready", {63'd0, rx_ready}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_idle_no_done", {63'd0, done}, 64'd0);
        check("midrst_idle_no_busy", {63'd0, busy}, 64'd0);
        run_load(1, 0, 0, -1, t);

        // Randomized loads, including empty/oversized lengths
        for (int i = 0; i < 12; i++) begin
            int len;
            int sel;
            sel = $urandom_range(9);
            if (sel == 0)      len = 0;
            else if (sel == 1) len = $urandom_range(65, 127);
            else               len = $urandom_range(1, 9);
            run_load(len, 0, $urandom_range(60), -1, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
